// File: rtl/ctrl_seq_if.sv
// Instruction-flow control bundle between the rysy core and ctrl_seq.
// Handshake semantics: dmem_req is held high while ctrl_seq waits in MEM;
// a cycle with dmem_req=1 and dmem_gnt=1 is the accepted transfer. For loads
// the data phase completes in the first cycle with dmem_rvalid=1 while
// waiting for read data. gnt/rvalid seen outside those states are ignored.
interface ctrl_seq_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       opcode;
    logic             b;
    logic             dmem_gnt;
    logic             dmem_rvalid;
    logic             reg_wr;
    logic             we;
    logic             dmem_req;
    logic [1:0]       pc_sel;
    logic [1:0]       inst_sel;
    logic             mem_sel;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] stall_cnt;

    // Controller side
    modport master (
        input  opcode, b, dmem_gnt, dmem_rvalid,
        output reg_wr, we, dmem_req, pc_sel, inst_sel, mem_sel, busy, err, stall_cnt
    );

    // Core / environment side
    modport slave (
        output opcode, b, dmem_gnt, dmem_rvalid,
        input  reg_wr, we, dmem_req, pc_sel, inst_sel, mem_sel, busy, err, stall_cnt
    );
endinterface

// File: rtl/ctrl_seq.sv
// Sequencing controller: owns pc_sel/inst_sel/mem_sel/reg_wr/we, handles
// variable-latency data memory (req/gnt/rvalid), post-redirect flush,
// wait timeout with sticky error, and a saturating stall counter.
module ctrl_seq #(
    parameter int FLUSH_DEPTH = 1,
    parameter int MAX_WAIT    = 15,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    ctrl_seq_if.master  bus,
    output logic [2:0]  o_state
);
    typedef enum logic [2:0] {
        S_FLUSH  = 3'd0,
        S_RUN    = 3'd1,
        S_MEM    = 3'd2,
        S_WAIT_R = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;

    localparam logic [1:0] PC_P4    = 2'd0;
    localparam logic [1:0] PC_ALU   = 2'd1;
    localparam logic [1:0] PC_OLD   = 2'd2;
    localparam logic [1:0] INST_MEM = 2'd0;
    localparam logic [1:0] INST_NOP = 2'd1;
    localparam logic [1:0] INST_OLD = 2'd2;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH);
    // Last wait count at which the awaited event may still arrive
    localparam logic [7:0] WAIT_LAST  = 8'(MAX_WAIT - 1);

    state_t           r_state, w_next;
    logic [2:0]       r_flush_cnt, w_flush_nxt;
    logic [7:0]       r_wait_cnt, w_wait_nxt;
    logic             r_err;
    logic [CNT_W-1:0] r_stall;

    logic [1:0] w_pc_sel, w_inst_sel;
    logic       w_mem_sel, w_reg_wr, w_we, w_req;

    // Next-state and output decode; reset overrides the enables and selects
    always_comb begin
        w_next      = r_state;
        w_flush_nxt = r_flush_cnt;
        w_wait_nxt  = r_wait_cnt;
        w_pc_sel    = PC_P4;
        w_inst_sel  = INST_MEM;
        w_mem_sel   = 1'b0;
        w_reg_wr    = 1'b0;
        w_we        = 1'b0;
        w_req       = 1'b0;
        case (r_state)
            S_FLUSH: begin
                w_inst_sel  = INST_NOP;
                w_flush_nxt = r_flush_cnt - 3'd1;
                if (r_flush_cnt <= 3'd1) w_next = S_RUN;
            end
            S_RUN: begin
                case (bus.opcode)
                    OPC_OP, OPC_OP_IMM, OPC_LUI: w_reg_wr = 1'b1;
                    OPC_JAL, OPC_JALR: begin
                        w_reg_wr    = 1'b1;
                        w_pc_sel    = PC_ALU;
                        w_inst_sel  = INST_NOP;
                        w_flush_nxt = FLUSH_LOAD;
                        w_next      = S_FLUSH;
                    end
                    OPC_BRANCH: begin
                        if (bus.b) begin
                            w_pc_sel    = PC_ALU;
                            w_inst_sel  = INST_NOP;
                            w_flush_nxt = FLUSH_LOAD;
                            w_next      = S_FLUSH;
                        end
                    end
                    OPC_LOAD, OPC_STORE: begin
                        w_pc_sel   = PC_OLD;
                        w_inst_sel = INST_OLD;
                        w_wait_nxt = 8'd0;
                        w_next     = S_MEM;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                w_req      = 1'b1;
                w_mem_sel  = 1'b1;
                w_we       = (bus.opcode == OPC_STORE);
                w_pc_sel   = PC_OLD;
                w_inst_sel = INST_OLD;
                if (bus.dmem_gnt)
                    w_next = (bus.opcode == OPC_STORE) ? S_WB : S_WAIT_R;
                else if (r_wait_cnt >= WAIT_LAST)
                    w_next = S_ERR;
                else
                    w_wait_nxt = r_wait_cnt + 8'd1;
            end
            S_WAIT_R: begin
                w_mem_sel  = 1'b1;
                w_pc_sel   = PC_OLD;
                w_inst_sel = INST_OLD;
                if (bus.dmem_rvalid)
                    w_next = S_WB;
                else if (r_wait_cnt >= WAIT_LAST)
                    w_next = S_ERR;
                else
                    w_wait_nxt = r_wait_cnt + 8'd1;
            end
            S_WB: begin
                // Fetch-realign slot: the held instruction is retired here
                w_inst_sel = INST_NOP;
                w_reg_wr   = (bus.opcode == OPC_LOAD);
                w_next     = S_RUN;
            end
            S_ERR: begin
                w_pc_sel   = PC_OLD;
                w_inst_sel = INST_NOP;
            end
            default: w_next = S_FLUSH;
        endcase
        if (rst) begin
            w_pc_sel   = PC_P4;
            w_inst_sel = INST_NOP;
            w_mem_sel  = 1'b0;
            w_reg_wr   = 1'b0;
            w_we       = 1'b0;
            w_req      = 1'b0;
        end
    end

    // State, counters, sticky error and saturating stall count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FLUSH;
            r_flush_cnt <= 3'd1;
            r_wait_cnt  <= 8'd0;
            r_err       <= 1'b0;
            r_stall     <= '0;
        end else begin
            r_state     <= w_next;
            r_flush_cnt <= w_flush_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_err       <= r_err | (w_next == S_ERR);
            if (w_pc_sel == PC_OLD && r_stall != '1)
                r_stall <= r_stall + CNT_W'(1);
        end
    end

    assign bus.reg_wr    = w_reg_wr;
    assign bus.we        = w_we;
    assign bus.dmem_req  = w_req;
    assign bus.pc_sel    = w_pc_sel;
    assign bus.inst_sel  = w_inst_sel;
    assign bus.mem_sel   = w_mem_sel;
    assign bus.busy      = (r_state == S_MEM) || (r_state == S_WAIT_R) || (r_state == S_WB);
    assign bus.err       = r_err;
    assign bus.stall_cnt = r_stall;
    assign o_state       = r_state;
endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq (FLUSH_DEPTH=3, MAX_WAIT=5, CNT_W=4).
// The driver applies one vector per cycle and queues its expected outputs;
// a negedge monitor pops and compares.
module tb_ctrl_seq;
  localparam int CNT_W = 4;
  localparam int W     = 11 + CNT_W;

  localparam logic [4:0] LOAD   = 5'b00000;
  localparam logic [4:0] STORE  = 5'b01000;
  localparam logic [4:0] BRANCH = 5'b11000;
  localparam logic [4:0] JAL    = 5'b11011;
  localparam logic [4:0] JALR   = 5'b11001;
  localparam logic [4:0] OP_IMM = 5'b00100;
  localparam logic [4:0] OP     = 5'b01100;
  localparam logic [4:0] LUI    = 5'b01101;
  localparam logic [4:0] UNK    = 5'b11111;

  localparam logic [1:0] P4 = 2'd0, ALU = 2'd1, OLD = 2'd2;
  localparam logic [1:0] IM = 2'd0, NOP = 2'd1, IO  = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  ctrl_seq_if #(.CNT_W(CNT_W)) bus ();

  ctrl_seq #(.FLUSH_DEPTH(3), .MAX_WAIT(5), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0]     exp_q[$];
  string            name_q[$];
  int               n_vec = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] m_stall;

  // driver: one cycle of stimulus plus its expected outputs
  task automatic step(input string nm, input logic r, input logic [4:0] op,
                      input logic bb, input logic g, input logic rv,
                      input logic e_rw, input logic e_we, input logic e_req,
                      input logic [1:0] e_pc, input logic [1:0] e_inst,
                      input logic e_mem, input logic e_busy, input logic e_err);
    @(posedge clk);
    #1;
    rst             = r;
    bus.opcode      = op;
    bus.b           = bb;
    bus.dmem_gnt    = g;
    bus.dmem_rvalid = rv;
    exp_q.push_back({e_rw, e_we, e_req, e_pc, e_inst, e_mem, e_busy, e_err, m_stall});
    name_q.push_back(nm);
    if (r) m_stall = '0;
    else if (e_pc == OLD && m_stall != '1) m_stall = m_stall + 1'b1;
  endtask

  // monitor
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    string        nm;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {bus.reg_wr, bus.we, bus.dmem_req, bus.pc_sel, bus.inst_sel,
             bus.mem_sel, bus.busy, bus.err, bus.stall_cnt};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s: got rw/we/req/pc/inst/mem/busy/err/stall=%b exp=%b", nm, got, exp);
      end
    end
  end

  initial begin
    rst             = 1'b1;
    bus.opcode      = OP;
    bus.b           = 1'b0;
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    m_stall = '0;

    // reset release with OP_IMM
    step("rst_hold",   1, OP_IMM, 0, 0, 0, 0, 0, 0, P4, NOP, 0, 0, 0);
    step("rst_flush",  0, OP_IMM, 0, 0, 0, 0, 0, 0, P4, NOP, 0, 0, 0);
    step("opimm_run",  0, OP_IMM, 0, 0, 0, 1, 0, 0, P4, IM,  0, 0, 0);
    step("op_run",     0, OP,     0, 0, 0, 1, 0, 0, P4, IM,  0, 0, 0);
    step("lui_run",    0, LUI,    0, 0, 0, 1, 0, 0, P4, IM,  0, 0, 0);
    step("unk_run",    0, UNK,    0, 0, 0, 0, 0, 0, P4, IM,  0, 0, 0);

    // JAL with FLUSH_DEPTH=3
    step("jal",        0, JAL,    0, 0, 0, 1, 0, 0, ALU, NOP, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("jal_flush", 0, OP,    0, 0, 0, 0, 0, 0, P4, NOP, 0, 0, 0);
    step("jal_after",  0, OP,     0, 0, 0, 1, 0, 0, P4, IM,  0, 0, 0);
    step("br_nt",      0, BRANCH, 0, 0, 0, 0, 0, 0, P4, IM,  0, 0, 0);
    step("br_nt_next", 0, OP,     0, 0, 0, 1, 0, 0, P4, IM,  0, 0, 0);
    step("br_t",       0, BRANCH, 1, 0, 0, 0, 0, 0, ALU, NOP, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("br_flush", 0, OP,     0, 0, 0, 0, 0, 0, P4, NOP, 0, 0, 0);
    step("jalr",       0, JALR,   0, 0, 0, 1, 0, 0, ALU, NOP, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("jalr_flush", 0, OP,   0, 0, 0, 0, 0, 0, P4, NOP, 0, 0, 0);
    step("jalr_after", 0, OP,     0, 0, 0, 1, 0, 0, P4, IM,  0, 0, 0);

    // STORE with gnt on the third MEM cycle: stall count goes 0 -> 4
    step("rst_c",      1, OP,     0, 0, 0, 0, 0, 0, P4, NOP, 0, 0, 0);
    step("flush_c",    0, STORE,  0, 0, 0, 0, 0, 0, P4, NOP, 0, 0, 0);
    step("st_run",     0, STORE,  0, 0, 0, 0, 0, 0, OLD, IO, 0, 0, 0);
    step("st_mem1",    0, STORE,  0, 0, 0, 0, 1, 1, OLD, IO, 1, 1, 0);
    step("st_mem2",    0, STORE,  0, 0, 0, 0, 1, 1, OLD, IO, 1, 1, 0);
    step("st_mem3",    0, STORE,  0, 1, 0, 0, 1, 1, OLD, IO, 1, 1, 0);
    step("st_wb",      0, STORE,  0, 0, 0, 0, 0, 0, P4, NOP, 0, 1, 0);
    step("st_next",    0, OP,     0, 0, 0, 1, 0, 0, P4, IM,  0, 0, 0);

    // stray gnt/rvalid in RUN, then LOAD with rvalid on the 4th WAIT_R cycle
    step("stray_rv",   0, OP,     0, 1, 1, 1, 0, 0, P4, IM,  0, 0, 0);
    step("ld_run",     0, LOAD,   0, 0, 0, 0, 0, 0, OLD, IO, 0, 0, 0);
    step("ld_mem",     0, LOAD,   0, 1, 0, 0, 0, 1, OLD, IO, 1, 1, 0);
    for (int i = 0; i < 3; i++)
      step("ld_waitr", 0, LOAD,   0, 0, 0, 0, 0, 0, OLD, IO, 1, 1, 0);
    step("ld_waitr4",  0, LOAD,   0, 0, 1, 0, 0, 0, OLD, IO, 1, 1, 0);
    step("ld_wb",      0, LOAD,   0, 0, 0, 1, 0, 0, P4, NOP, 0, 1, 0);
    step("ld_next",    0, OP,     0, 0, 0, 1, 0, 0, P4, IM,  0, 0, 0);

    // gnt on exactly the 5th MEM cycle beats the timeout
    step("st5_run",    0, STORE,  0, 0, 0, 0, 0, 0, OLD, IO, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step("st5_mem",  0, STORE,  0, 0, 0, 0, 1, 1, OLD, IO, 1, 1, 0);
    step("st5_mem5",   0, STORE,  0, 1, 0, 0, 1, 1, OLD, IO, 1, 1, 0);
    step("st5_wb",     0, STORE,  0, 0, 0, 0, 0, 0, P4, NOP, 0, 1, 0);
    step("st5_next",   0, OP,     0, 0, 0, 1, 0, 0, P4, IM,  0, 0, 0);

    // reset asserted while waiting for read data
    step("g_run",      0, LOAD,   0, 0, 0, 0, 0, 0, OLD, IO, 0, 0, 0);
    step("g_mem",      0, LOAD,   0, 1, 0, 0, 0, 1, OLD, IO, 1, 1, 0);
    step("g_waitr",    0, LOAD,   0, 0, 0, 0, 0, 0, OLD, IO, 1, 1, 0);
    step("g_rst",      1, LOAD,   0, 1, 1, 0, 0, 0, P4, NOP, 0, 1, 0);
    step("g_flush",    0, LOAD,   0, 1, 1, 0, 0, 0, P4, NOP, 0, 0, 0);
    step("g_run2",     0, OP,     0, 0, 0, 1, 0, 0, P4, IM,  0, 0, 0);

    // LOAD without gnt: timeout, 20 cycles of ERR, stall saturates at 15
    step("to_run",     0, LOAD,   0, 0, 0, 0, 0, 0, OLD, IO, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step("to_mem",   0, LOAD,   0, 0, 0, 0, 0, 1, OLD, IO, 1, 1, 0);
    for (int i = 0; i < 20; i++)
      step("to_err",   0, LOAD,   0, (i % 3 == 0), (i % 4 == 1), 0, 0, 0, OLD, NOP, 0, 0, 1);
    step("to_rst",     1, OP,     0, 0, 0, 0, 0, 0, P4, NOP, 0, 0, 1);
    step("to_flush",   0, OP,     0, 0, 0, 0, 0, 0, P4, NOP, 0, 0, 0);
    step("to_run2",    0, OP,     0, 0, 0, 1, 0, 0, P4, IM,  0, 0, 0);

    // drain and report
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Parametrised sequencing controller for the rysy core; successor to the two-flag (next_nop/load_phase) sequencing inside ctrl. It owns instruction-flow control: `pc_sel`, `inst_sel`, `mem_sel`, `reg_wr` and `we`. It adds variable-latency data-memory handshaking (req/gnt/rvalid), a configurable post-redirect flush depth, a wait timeout with a sticky error, and a saturating stall counter. Decode of `imm_type`, `alu_op`, `cmp_op`, `sel_type` and `rd_sel` stays in ctrl.

## Interface
- `FLUSH_DEPTH`, default 1: NOP cycles inserted after a taken redirect (JAL, JALR, taken BRANCH). Legal range 1..7.
- `MAX_WAIT`, default 15: cycles allowed in MEM or WAIT_R before timeout. Legal range 1..255.
- `CNT_W`, default 16: width of `stall_cnt`.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 5: instr[6:2], per opcodes.vh (LOAD 00000, STORE 01000, BRANCH 11000, JAL 11011, JALR 11001, OP_IMM 00100, OP 01100, LUI 01101).
- `b` in 1: branch-taken from cmp.
- `dmem_gnt` in 1: memory accepted request.
- `dmem_rvalid` in 1: load data valid.
- `reg_wr` out 1: register-file write enable.
- `we` out 1: memory write enable.
- `dmem_req` out 1: data request.
- `pc_sel` out 2: P4=0, ALU=1, OLD=2.
- `inst_sel` out 2: MEM=0, NOP=1, OLD=2.
- `mem_sel` out 1: PC=0, ALU=1.
- `busy` out 1: in MEM, WAIT_R or WB.
- `err` out 1: sticky timeout flag.
- `stall_cnt` out CNT_W: saturating count of cycles with `pc_sel`=OLD.

## Operation
- States: FLUSH, RUN, MEM, WAIT_R, WB, ERR. State register, flush counter (3 b) and wait counter (8 b) are sequential. All outputs are decoded from the state and the inputs.
- Defaults in every state: pc_sel=P4, inst_sel=MEM, mem_sel=PC, reg_wr=0, we=0, dmem_req=0.
- FLUSH: inst_sel=NOP. Flush counter decrements each cycle. Move to RUN in the cycle the counter reads 1.
- RUN, decoded by `opcode`:
  - OP, OP_IMM, LUI: reg_wr=1.
  - JAL, JALR: reg_wr=1, pc_sel=ALU, inst_sel=NOP. Load flush counter with FLUSH_DEPTH and go to FLUSH.
  - BRANCH with b=1: pc_sel=ALU, inst_sel=NOP, then FLUSH as above. BRANCH with b=0: defaults.
  - LOAD, STORE: pc_sel=OLD, inst_sel=OLD, clear wait counter, go to MEM.
  - Any other opcode: defaults (treated as a NOP).
- MEM: dmem_req=1, mem_sel=ALU, we=(opcode==STORE), pc_sel=OLD, inst_sel=OLD. `opcode` stays stable because inst_sel=OLD.
  - On dmem_gnt, STORE goes to WB and LOAD goes to WAIT_R.
  - Otherwise the wait counter increments.
- WAIT_R: mem_sel=ALU, pc_sel=OLD, inst_sel=OLD. On dmem_rvalid go to WB; otherwise the wait counter increments.
- WB: pc_sel=P4, inst_sel=NOP, reg_wr=(opcode==LOAD). This is the fetch-realign slot. Go to RUN next cycle.
- Timeout: wait counter reaching MAX_WAIT in MEM or WAIT_R without the awaited event moves the FSM to ERR. A gnt or rvalid arriving in that same cycle wins, and no timeout occurs.
- ERR: err=1, pc_sel=OLD, inst_sel=NOP, all enables 0. Only `rst` leaves ERR.
- stall_cnt: increments each cycle pc_sel==OLD and holds at 2^CNT_W−1. Reset clears it to 0.
- A dmem_rvalid outside WAIT_R and a dmem_gnt outside MEM are ignored.

## Timing
- Reset: while rst=1, outputs are forced to inst_sel=NOP, reg_wr=0, we=0, dmem_req=0, pc_sel=P4, mem_sel=PC. This applies in any state, including mid-transaction.
- At the rst edge: state←FLUSH, flush counter←1, wait counter←0, err←0, stall_cnt←0.
- After release there is exactly one NOP cycle, then RUN. The first instruction is never executed twice.
- Redirect cycle count: 1 + FLUSH_DEPTH cycles with inst_sel=NOP before the next MEM-sourced instruction.
- Store with gnt at the first MEM cycle: RUN, MEM, WB, 3 cycles total, with we=1 for exactly 1 cycle.
- Load with gnt at the first MEM cycle and rvalid N cycles later: 3+N cycles, with reg_wr=1 only in WB.
- Back-to-back memory ops are legal. RUN→MEM is re-entered only after WB→RUN.

## Test plan
- Reset release with OP_IMM: exactly 1 cycle inst_sel=1, then reg_wr=1 with pc_sel=0. Assert rst in WAIT_R: the next cycle after release is FLUSH, and dmem_req never rises.
- JAL, FLUSH_DEPTH=3: one cycle with pc_sel=1, inst_sel=1, reg_wr=1, then 3 cycles inst_sel=1 and reg_wr=0, then inst_sel=0. BRANCH with b=0: no NOP cycles.
- STORE with gnt delayed 2 cycles: dmem_req=1 and we=1 for 3 cycles, then WB, then RUN. stall_cnt advances by 4.
- LOAD with gnt immediate and rvalid after 4 cycles: reg_wr=1 only in the WB cycle, and mem_sel=1 throughout MEM and WAIT_R. A stray rvalid during RUN changes nothing.
- LOAD, MAX_WAIT=5, no gnt: ERR entered on the cycle the counter reaches 5, err=1 held for 20 cycles until rst. gnt arriving exactly at the 5th cycle must not set err.
- CNT_W=4 with a 20-cycle stall: stall_cnt saturates at 15.
